// File: rtl/rr_decode_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_decode_arbiter_pkg
// Shared definitions for the round-robin decode arbiter:
//   - state_e          : arbiter state encoding (IDLE = no owner, BUSY = owned)
//   - hold_cnt_width() : width of the consecutive-grant counter for a given
//                        hold limit, never narrower than one bit
// -----------------------------------------------------------------------------
package rr_decode_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Enough bits to count 0..max_hold; a zero limit still yields a 1-bit counter.
    function automatic int hold_cnt_width(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : rr_decode_arbiter_pkg

// File: rtl/rr_decode_arbiter_decoder_3_8.sv
// -----------------------------------------------------------------------------
// decoder_3_8
// Shift-based N-to-2**N one-hot decoder (3-to-8 at the default N).
// Ports:
//   idx  input  [N-1:0]     binary index
//   dout output [2**N-1:0]  one-hot code with bit idx set
// Purely combinational.
// -----------------------------------------------------------------------------
module decoder_3_8 #(
    parameter int N = 3
) (
    input  logic [N-1:0]      idx,
    output logic [2**N-1:0]   dout
);

    localparam int NOUT = 2**N;

    // A single set LSB shifted into position gives the one-hot code.
    always_comb begin
        dout = {{(NOUT-1){1'b0}}, 1'b1} << idx;
    end

endmodule : decoder_3_8

// File: rtl/rr_decode_arbiter.sv
// -----------------------------------------------------------------------------
// rr_decode_arbiter
// Round-robin arbiter sharing one resource among 2**N requesters. The winner
// index is found by a rotating-priority search starting just after the most
// recent owner, expanded to one-hot by decoder_3_8, and registered into gnt.
// The owner keeps the grant while it requests, up to MAX_HOLD consecutive
// cycles when someone else is waiting (MAX_HOLD = 0 means no limit).
// Ports:
//   clk        input   rising-edge clock
//   rst        input   synchronous active-high reset
//   req        input   [2**N-1:0] level-sensitive requests
//   gnt        output  [2**N-1:0] registered one-hot grant, zero when idle
//   gnt_idx    output  [N-1:0]    index of the current owner (valid with gnt_valid)
//   gnt_valid  output  high while a grant is held
// -----------------------------------------------------------------------------
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    output logic [2**N-1:0]   gnt,
    output logic [N-1:0]      gnt_idx,
    output logic              gnt_valid
);

    localparam int NREQ = 2**N;
    localparam int HW   = hold_cnt_width(MAX_HOLD);
    // Counter value on the last permitted consecutive cycle.
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    // {found, index}: first requester after ptr, wrapping; ptr itself is checked last.
    function automatic logic [N:0] find_winner(input logic [NREQ-1:0] r,
                                               input logic [N-1:0]    ptr);
        logic [N:0]   res;
        logic [N-1:0] cand;
        res = {(N+1){1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            cand = ptr + N'(i);
            if (!res[N] && r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_e             state_q,    state_d;
    logic [NREQ-1:0]    gnt_q,      gnt_d;
    logic [N-1:0]       gnt_idx_q,  gnt_idx_d;
    logic [N-1:0]       last_q,     last_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;

    logic               owner_req_s;
    logic               others_s;
    logic               limit_hit_s;
    logic               rearb_s;
    logic [N:0]         win_s;
    logic [NREQ-1:0]    win_onehot_s;

    // Re-arbitration triggers: idle, owner release, or hold limit with contenders.
    always_comb begin
        owner_req_s = req[gnt_idx_q];
        others_s    = |(req & ~gnt_q);
        limit_hit_s = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        rearb_s     = (state_q == IDLE) || !owner_req_s || (limit_hit_s && others_s);
        win_s       = find_winner(req, last_q);
    end

    decoder_3_8 #(
        .N (N)
    ) u_decoder (
        .idx  (win_s[N-1:0]),
        .dout (win_onehot_s)
    );

    // Next-state computation for ownership, pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        if (rearb_s) begin
            if (win_s[N]) begin
                state_d    = BUSY;
                gnt_d      = win_onehot_s;
                gnt_idx_d  = win_s[N-1:0];
                last_d     = win_s[N-1:0];
                hold_cnt_d = {HW{1'b0}};
            end else begin
                // Nobody requesting: drop the grant, keep idx and pointer.
                state_d    = IDLE;
                gnt_d      = {NREQ{1'b0}};
                hold_cnt_d = {HW{1'b0}};
            end
        end else begin
            if (MAX_HOLD == 0) begin
                hold_cnt_d = {HW{1'b0}};
            end else if (limit_hit_s) begin
                // Limit reached but uncontested: restart the count, never overflow.
                hold_cnt_d = {HW{1'b0}};
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    // State registers with synchronous reset; pointer resets so index 0 leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= {NREQ{1'b0}};
            gnt_idx_q  <= {N{1'b0}};
            last_q     <= {N{1'b1}};
            hold_cnt_q <= {HW{1'b0}};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == BUSY);

endmodule : rr_decode_arbiter

// File: tb/tb_rr_decode_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_decode_arbiter
// Directed bench for rr_decode_arbiter: a table of per-cycle vectors for the
// default configuration (N=3, MAX_HOLD=4), then hand-written sequences for
// full rotation and for an unlimited-hold instance (MAX_HOLD=0).
// -----------------------------------------------------------------------------
module tb_rr_decode_arbiter;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic       exp_valid;
        logic [2:0] exp_idx;
    } vec_t;

    localparam int NVEC = 34;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt4, gnt0;
    logic [2:0] idx4, idx0;
    logic       v4, v0;

    int tests;
    int fails;
    vec_t vecs [NVEC];

    rr_decode_arbiter #(.N(3), .MAX_HOLD(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt4),
        .gnt_idx   (idx4),
        .gnt_valid (v4)
    );

    rr_decode_arbiter #(.N(3), .MAX_HOLD(0)) u_dut_nohold (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt0),
        .gnt_idx   (idx0),
        .gnt_valid (v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [7:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 8'h00;

        // {rst, req, expected gnt, expected valid, expected idx}
        vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0}; // reset
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0}; // idle
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[4]  = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0}; // first grant, 1 cycle
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0}; // release -> idle, idx held
        for (int i = 6; i <= 15; i++)                 // owner 3 alone 10 cycles
            vecs[i] = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[16] = '{1'b0, 8'h20, 8'h20, 1'b1, 3'd5}; // 3 releases, 5 wins
        vecs[17] = '{1'b0, 8'h62, 8'h20, 1'b1, 3'd5}; // 5 holds, 6 and 1 wait
        vecs[18] = '{1'b0, 8'h42, 8'h40, 1'b1, 3'd6}; // 5 drops: 6 before 1
        vecs[19] = '{1'b0, 8'h02, 8'h02, 1'b1, 3'd1}; // 6 drops: 1
        vecs[20] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd1}; // idle, idx held
        vecs[21] = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2}; // owner 2
        vecs[22] = '{1'b0, 8'h84, 8'h04, 1'b1, 3'd2};
        vecs[23] = '{1'b1, 8'h84, 8'h00, 1'b0, 3'd0}; // reset mid-grant
        vecs[24] = '{1'b0, 8'h84, 8'h04, 1'b1, 3'd2}; // pointer at 7: 2 beats 7
        vecs[25] = '{1'b0, 8'h84, 8'h04, 1'b1, 3'd2};
        vecs[26] = '{1'b0, 8'h84, 8'h04, 1'b1, 3'd2};
        vecs[27] = '{1'b0, 8'h84, 8'h04, 1'b1, 3'd2}; // 4th held cycle
        vecs[28] = '{1'b0, 8'h84, 8'h80, 1'b1, 3'd7}; // timeout hands to 7
        vecs[29] = '{1'b0, 8'h84, 8'h80, 1'b1, 3'd7};
        vecs[30] = '{1'b0, 8'h84, 8'h80, 1'b1, 3'd7};
        vecs[31] = '{1'b0, 8'h84, 8'h80, 1'b1, 3'd7};
        vecs[32] = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2}; // release at limit
        vecs[33] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd2};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d gnt", i), gnt4, vecs[i].exp_gnt);
            check($sformatf("vec%0d valid", i), {7'd0, v4}, {7'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d idx", i), {5'd0, idx4}, {5'd0, vecs[i].exp_idx});
        end

        // All requesting: each owner holds 4 cycles, rotation 0..7 then back to 0.
        step(1'b1, 8'h00);
        for (int k = 0; k <= 32; k++) begin
            logic [7:0] exp_g;
            exp_g = 8'h01 << ((k / 4) % 8);
            step(1'b0, 8'hFF);
            check($sformatf("rot%0d gnt", k), gnt4, exp_g);
            check($sformatf("rot%0d valid", k), {7'd0, v4}, 8'h01);
        end

        // Unlimited hold: owner 0 keeps the grant against a waiting requester 1.
        step(1'b1, 8'h00);
        check("nohold reset gnt", gnt0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 8'h03);
            check($sformatf("nohold%0d gnt", k), gnt0, 8'h01);
        end
        step(1'b0, 8'h02);
        check("nohold handoff gnt", gnt0, 8'h02);
        check("nohold handoff idx", {5'd0, idx0}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rr_decode_arbiter
